// File: rtl/pushbutton_conditioner_pkg.sv
// Shared constants for the pushbutton front end of the uP input port.
// Holds the data-bus width, the IN strobe index and debounce defaults.
package pushbutton_conditioner_pkg;

   localparam int UP_DATA_W               = 4;
   localparam int UP_CS_IN                = 2;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
   localparam int DEBOUNCE_CYCLES_SIM     = 4;

   // The counter must be able to hold DEBOUNCE_CYCLES itself, hence the +1.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/pushbutton_conditioner_debounce_cell.sv
// One button: synchronizer chain, stability counter and debounced level.
// rise flags the edge on which the level is about to go 0->1.
module debounce_cell
   import pushbutton_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CW-1:0]          cnt;
   logic                   accept;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign accept = (sync != level) && (cnt == CNT_LAST);
   assign rise   = accept && sync;

   // NOTE: the raw input feeds the first flop directly; any gate in front of
   // the chain would let a metastable or glitching value fan out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      end
   end

   // Any cycle where sync agrees with the accepted level restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync == level) begin
         cnt <= '0;
      end else if (accept) begin
         level <= sync;
         cnt   <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pushbutton_conditioner.sv
// Conditions the raw pushbuttons for the uP IN port: per-button debounce,
// sticky press-event flags cleared by the IN strobe, and a level/event mux.
module pushbutton_conditioner
   import pushbutton_conditioner_pkg::*;
#(
   parameter int N_BTN           = UP_DATA_W,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic             sel_event,
   input  logic             rd_ack,
   output logic [N_BTN-1:0] pb_data,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_event,
   output logic             event_pending
);

   logic [N_BTN-1:0] rise;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_cell #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .btn_raw (btn_raw[i]),
         .level   (btn_level[i]),
         .rise    (rise[i])
      );
   end

   // Set is OR-ed after the clear so a press landing on the ack edge survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_event <= '0;
      end else begin
         btn_event <= (btn_event & ~{N_BTN{rd_ack}}) | rise;
      end
   end

   assign pb_data       = sel_event ? btn_event : btn_level;
   assign event_pending = |btn_event;

endmodule
